uart_irq_ctrl: RTL and testbench
================================

// Module: uart_irq_ctrl
// PURPOSE
//  SoC-side 8N1 UART: serialises bytes from the CPU onto ser_tx and deserialises ser_rx
//  into a one-byte receive holding register. Level interrupt for receive events and TX-empty.
//  Faces the 9600-baud bench UART model on the pads; firmware interrupt tests use it.
// PARAMETERS
//  CLKS_PER_BIT  4167  clock cycles per bit period (40 MHz / 9600 baud); legal range 4..65535
//  DIV_W         16    width of the bit-period counters
// PORTS
//  wb_clk_i      in   1  single clock; all logic on the rising edge
//  wb_rst_i      in   1  synchronous reset, active-high
//  ser_rx        in   1  serial input, asynchronous, idles high
//  ser_tx        out  1  serial output, idles high
//  tx_data       in   8  byte to send; sampled on accept
//  tx_valid      in   1  send request
//  tx_ready      out  1  high in TX IDLE; accept = tx_valid & tx_ready
//  tx_done       out  1  one-cycle pulse on the last cycle of the stop bit
//  rx_data       out  8  last good byte received
//  rx_valid      out  1  rx_data holds an unread byte
//  rx_ack        in   1  one-cycle read strobe
//  rx_overrun    out  1  sticky: byte completed while rx_valid was 1
//  rx_frame_err  out  1  sticky: stop bit sampled low
//  irq_en        in   2  [0] enables RX interrupt, [1] enables TX-empty interrupt
//  irq           out  1  (irq_en[0] & (rx_valid|rx_overrun|rx_frame_err)) | (irq_en[1] & tx_ready)
// BEHAVIOUR
//  Reset: both FSMs IDLE; counters 0; ser_tx=1; tx_ready=1; tx_done=0; rx_data=0;
//   rx_valid/rx_overrun/rx_frame_err=0; sync flops=1. No accept while wb_rst_i=1.
//  Reset mid-frame aborts immediately: ser_tx is 1 the cycle after the reset edge; partial RX byte discarded.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: tx_ready=1. On accept, latch tx_data and go to START; tx_ready=0 from the next cycle.
//   - START: ser_tx=0 for CLKS_PER_BIT cycles.
//   - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
//   - STOP: ser_tx=1 for CLKS_PER_BIT cycles; tx_done pulses on its last cycle.
//   - Timing: first START cycle is accept+1; tx_ready=1 again at accept+1+10*CLKS_PER_BIT.
//   - tx_data changes after accept have no effect. Back-to-back frames have no idle gap.
//  RX path:
//   - Synchroniser: ser_rx passes through 2 flops (reset 1); the FSM uses only the synced bit.
//   - IDLE -> START on synced low.
//   - START: wait CLKS_PER_BIT/2 cycles (integer divide). Re-sample: low -> DATA; high -> IDLE (glitch, no flags).
//   - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shift in LSB first.
//   - STOP: sample after CLKS_PER_BIT cycles.
//     - High, rx_valid=0 or rx_ack same cycle: load rx_data; rx_valid=1 next cycle; no overrun.
//     - High, rx_valid=1 and no rx_ack: rx_overrun=1; rx_data keeps the old byte.
//     - Low: rx_frame_err=1; byte discarded; go to BREAK.
//   - BREAK: wait for synced high, then IDLE.
//   - STOP high returns to IDLE in the same cycle, so the next start bit can be detected at once.
//  rx_ack clears rx_valid, rx_overrun and rx_frame_err on the next cycle.
//   If a flag-setting event lands in the same cycle, the event wins.
//  Counters: DIV_W bits, count 0..CLKS_PER_BIT-1, then wrap to 0.
//   They never hit 2^DIV_W because CLKS_PER_BIT <= 2^DIV_W-1.
//  TX and RX are fully independent; loopback (ser_tx tied to ser_rx) must work.
// TESTING (CLKS_PER_BIT=16 unless noted)
//  1. tx_data=8'hA5, tx_valid 1 cycle at t0:
//     - ser_tx from t0+1 = 0,1,0,1,0,0,1,0,1,1, each 16 cycles;
//     - tx_done at t0+160; tx_ready=1 at t0+161.
//  2. Drive ser_rx with frame 8'h3C at 16 cycles/bit:
//     - rx_valid=1 and rx_data=8'h3C within 16+2 cycles of the stop-bit midpoint;
//     - irq=1 with irq_en=2'b01; rx_ack -> rx_valid=0, irq=0.
//  3. Send 8'h11 then 8'h22 with no rx_ack:
//     - rx_data stays 8'h11 and rx_overrun=1;
//     - rx_ack pulsed on the cycle the 8'h22 stop bit is sampled -> rx_data=8'h22, rx_valid=1, rx_overrun=0.
//  4. Frame 8'h55 with the stop bit held low for 3 bit times:
//     - rx_frame_err=1, rx_valid=0;
//     - a following valid frame 8'h0F is received correctly after the line returns high.
//  5. 5-cycle low glitch on ser_rx -> no state change, no flags.
//     Assert wb_rst_i mid-TX at bit 4 -> ser_tx=1 and tx_ready=1 after the reset cycle; rx_valid=0.
//  6. CLKS_PER_BIT=4167, loopback ser_tx->ser_rx plus the 9600-baud bench model:
//     - bytes 8'h00, 8'hFF, 8'h5A round-trip intact;
//     - irq with irq_en=2'b10 follows tx_ready.

Source files
------------

// File: rtl/uart_irq_ctrl.sv
// rtl/uart_irq_ctrl.sv - 8N1 UART with one-byte receive holding register and level interrupt
module uart_irq_ctrl #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int DIV_W        = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic [1:0] irq_en,
  output logic       irq
);

  localparam logic [DIV_W-1:0] CNT_MAX  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] HALF_MAX = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             ser_tx_q, ser_tx_d;
  logic             tx_cnt_end;

  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             rx_frame_err_q, rx_frame_err_d;
  logic             rx_sync1_q, rx_sync1_d;
  logic             rx_sync2_q, rx_sync2_d;
  logic             rx_cnt_end;

  assign tx_cnt_end = (tx_cnt_q == CNT_MAX);
  assign rx_cnt_end = (rx_cnt_q == CNT_MAX);

  // TX next state; ser_tx is registered from the next state so the pad never glitches
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_byte_d  = tx_data;
          tx_cnt_d   = CNT_ZERO;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = CNT_ZERO;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_end) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = CNT_ZERO;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CNT_ZERO;
      end
    endcase
    case (tx_state_d)
      TX_START: ser_tx_d = 1'b0;
      TX_DATA:  ser_tx_d = tx_byte_d[tx_bit_d];
      default:  ser_tx_d = 1'b1;
    endcase
  end

  // TX registers; reset drops any frame in flight and returns the line high
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_bit_q   <= 3'd0;
      tx_byte_q  <= 8'h00;
      ser_tx_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      ser_tx_q   <= ser_tx_d;
    end
  end

  // RX next state and flags; a flag-setting event overrides a same-cycle rx_ack clear
  always_comb begin
    rx_sync1_d     = ser_rx;
    rx_sync2_d     = rx_sync1_q;
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    rx_overrun_d   = rx_overrun_q;
    rx_frame_err_d = rx_frame_err_q;
    if (rx_ack) begin
      rx_valid_d     = 1'b0;
      rx_overrun_d   = 1'b0;
      rx_frame_err_d = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync2_q) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_MAX) begin
          rx_cnt_d = CNT_ZERO;
          rx_bit_d = 3'd0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_end) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_end) begin
          rx_cnt_d = CNT_ZERO;
          if (rx_sync2_q) begin
            rx_state_d = RX_IDLE;
            if (!rx_valid_q || rx_ack) begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
          end else begin
            rx_frame_err_d = 1'b1;
            rx_state_d     = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_BREAK: begin
        if (rx_sync2_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // RX registers including the two-flop synchroniser on ser_rx
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= CNT_ZERO;
      rx_bit_q       <= 3'd0;
      rx_shift_q     <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_sync1_q     <= rx_sync1_d;
      rx_sync2_q     <= rx_sync2_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign ser_tx       = ser_tx_q;
  assign tx_ready     = (tx_state_q == TX_IDLE);
  assign tx_done      = (tx_state_q == TX_STOP) && tx_cnt_end;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
  assign irq = (irq_en[0] & (rx_valid_q | rx_overrun_q | rx_frame_err_q)) |
               (irq_en[1] & tx_ready);

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb/tb_uart_irq_ctrl.sv - directed table-driven bench for uart_irq_ctrl at 16 clocks per bit
module tb_uart_irq_ctrl;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       ser_rx;
  logic       ser_rx_drv;
  logic       loop_sel;
  logic       ser_tx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic [1:0] irq_en;
  logic       irq;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    bit         pre_ack;
    bit         stop_low;
    int         ack_at;
    logic [7:0] exp_data;
    bit         exp_v;
    bit         exp_o;
    bit         exp_f;
  } rx_vec_t;

  tx_vec_t tx_tbl[4];
  rx_vec_t rx_tbl[8];

  always #5 clk = ~clk;

  assign ser_rx = loop_sel ? ser_tx : ser_rx_drv;

  uart_irq_ctrl #(.CLKS_PER_BIT(CPB), .DIV_W(16)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .irq_en       (irq_en),
    .irq          (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  // accept one byte and check every cycle of its frame against the expected bit pattern
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] frame);
    int guard;
    guard = 0;
    while (!tx_ready && guard < 400) begin
      tick();
      guard++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~b;
    for (int k = 1; k <= 10 * CPB; k++) begin
      check("tx_ser", ser_tx, frame[(k - 1) / CPB]);
      check("tx_done", tx_done, (k == 10 * CPB));
      check("tx_busy", tx_ready, 0);
      if (k == 80 && irq_en == 2'b10) check("irq_tx_busy", irq, 0);
      tick();
    end
    check("tx_ready_back", tx_ready, 1);
    check("tx_idle_line", ser_tx, 1);
  endtask

  // drive one 8N1 frame on ser_rx; optional rx_ack pulse at cycle ack_at of the frame
  task automatic rx_frame(input logic [7:0] b, input bit stop_low, input int ack_at);
    int len;
    int bitpos;
    logic v;
    len = stop_low ? 13 * CPB : 10 * CPB;
    for (int k = 0; k < len; k++) begin
      bitpos = k / CPB;
      if (bitpos == 0) v = 1'b0;
      else if (bitpos <= 8) v = b[bitpos - 1];
      else if (stop_low && bitpos <= 11) v = 1'b0;
      else v = 1'b1;
      ser_rx_drv = v;
      rx_ack = (k == ack_at);
      tick();
    end
    rx_ack = 1'b0;
    ser_rx_drv = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_tbl[0] = '{8'hA5, {1'b1, 8'hA5, 1'b0}};
    tx_tbl[1] = '{8'h00, 10'b1_00000000_0};
    tx_tbl[2] = '{8'hFF, 10'b1_11111111_0};
    tx_tbl[3] = '{8'h5A, 10'b1_01011010_0};

    rx_tbl[0] = '{8'h3C, 1'b1, 1'b0, -1,  8'h3C, 1'b1, 1'b0, 1'b0};
    rx_tbl[1] = '{8'h11, 1'b1, 1'b0, -1,  8'h11, 1'b1, 1'b0, 1'b0};
    rx_tbl[2] = '{8'h22, 1'b0, 1'b0, -1,  8'h11, 1'b1, 1'b1, 1'b0};
    rx_tbl[3] = '{8'h22, 1'b0, 1'b0, 154, 8'h22, 1'b1, 1'b0, 1'b0};
    rx_tbl[4] = '{8'h55, 1'b1, 1'b1, -1,  8'h22, 1'b0, 1'b0, 1'b1};
    rx_tbl[5] = '{8'h0F, 1'b0, 1'b0, -1,  8'h0F, 1'b1, 1'b0, 1'b1};
    rx_tbl[6] = '{8'h00, 1'b1, 1'b0, -1,  8'h00, 1'b1, 1'b0, 1'b0};
    rx_tbl[7] = '{8'hFF, 1'b0, 1'b0, -1,  8'h00, 1'b1, 1'b1, 1'b0};

    wb_rst_i   = 1'b1;
    ser_rx_drv = 1'b1;
    loop_sel   = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    rx_ack     = 1'b0;
    irq_en     = 2'b10;
    tick();
    tick();
    tick();
    wb_rst_i = 1'b0;
    tick();

    check("rst_ser_tx", ser_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_overrun", rx_overrun, 0);
    check("rst_rx_frame_err", rx_frame_err, 0);
    check("rst_irq_txempty", irq, 1);
    irq_en = 2'b01;
    #1;
    check("rst_irq_rx_only", irq, 0);
    irq_en = 2'b10;

    for (int i = 0; i < 4; i++) tx_frame(tx_tbl[i].data, tx_tbl[i].frame);

    irq_en = 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (rx_tbl[i].pre_ack) pulse_ack();
      rx_frame(rx_tbl[i].data, rx_tbl[i].stop_low, rx_tbl[i].ack_at);
      check("rx_data", rx_data, rx_tbl[i].exp_data);
      check("rx_valid", rx_valid, rx_tbl[i].exp_v);
      check("rx_overrun", rx_overrun, rx_tbl[i].exp_o);
      check("rx_frame_err", rx_frame_err, rx_tbl[i].exp_f);
      check("rx_irq", irq, rx_tbl[i].exp_v | rx_tbl[i].exp_o | rx_tbl[i].exp_f);
    end

    pulse_ack();
    check("ack_clr_valid", rx_valid, 0);
    check("ack_clr_overrun", rx_overrun, 0);
    check("ack_irq_low", irq, 0);

    ser_rx_drv = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    ser_rx_drv = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    check("glitch_valid", rx_valid, 0);
    check("glitch_overrun", rx_overrun, 0);
    check("glitch_frame_err", rx_frame_err, 0);
    check("glitch_data", rx_data, 8'h00);
    rx_frame(8'hA7, 1'b0, -1);
    check("post_glitch_data", rx_data, 8'hA7);
    check("post_glitch_valid", rx_valid, 1);

    loop_sel = 1'b1;
    irq_en   = 2'b10;
    for (int i = 1; i < 4; i++) begin
      pulse_ack();
      tx_frame(tx_tbl[i].data, tx_tbl[i].frame);
      check("loop_rx_data", rx_data, tx_tbl[i].data);
      check("loop_rx_valid", rx_valid, 1);
      check("loop_frame_err", rx_frame_err, 0);
      check("loop_irq_follows_ready", irq, 1);
    end

    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k < 17 + 4 * CPB + 5; k++) tick();
    check("mid_tx_bit4", ser_tx, 0);
    check("mid_tx_busy", tx_ready, 0);
    wb_rst_i = 1'b1;
    tx_valid = 1'b1;
    tick();
    check("rst_mid_ser_tx", ser_tx, 1);
    check("rst_mid_tx_ready", tx_ready, 1);
    check("rst_mid_rx_valid", rx_valid, 0);
    check("rst_mid_rx_data", rx_data, 8'h00);
    tick();
    wb_rst_i = 1'b0;
    tx_valid = 1'b0;
    tick();
    check("no_accept_in_rst", tx_ready, 1);
    check("no_accept_line", ser_tx, 1);
    for (int k = 0; k < 200; k++) tick();
    check("partial_rx_dropped", rx_valid, 0);
    check("partial_rx_no_ferr", rx_frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
